// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared definitions for the RC4 memory subsystem.
//   Default memory geometry (address/data width), the fixed requester
//   indices used by the engine blocks, the arbiter state encoding, and a
//   helper that sizes an index field for a given requester count.
package rc4_pkg;

   localparam int ARB_AW  = 8;
   localparam int ARB_DW  = 8;
   localparam int REQ_NUM = 3;

   // Requester indices; lower index wins arbitration.
   localparam int REQ_INIT = 0;
   localparam int REQ_KSA  = 1;
   localparam int REQ_PRGA = 2;

   typedef enum logic [0:0] {
      ST_ARB = 1'b0,
      ST_OWN = 1'b1
   } arb_state_e;

   // Width of an index able to address n requesters (never zero).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/s_mem_arbiter_if.sv
// s_mem_arbiter_if -- requester-side bus of the shared S-RAM arbiter.
//   req/wren/addr/wdata : per-requester request, write enable, packed
//                         address and write data (requester i at [i*W +: W])
//   gnt/rvalid          : one-hot-or-zero grant and read-return strobe
//   rdata               : shared read data, qualified by rvalid
//   busy                : memory currently owned
//   modport master = requester side, modport slave = arbiter side.
interface s_mem_arbiter_if
   import rc4_pkg::*;
#(
   parameter int N_REQ = REQ_NUM,
   parameter int AW    = ARB_AW,
   parameter int DW    = ARB_DW
);

   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    wren;
   logic [N_REQ*AW-1:0] addr;
   logic [N_REQ*DW-1:0] wdata;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    rvalid;
   logic [DW-1:0]       rdata;
   logic                busy;

   modport master (
      output req, wren, addr, wdata,
      input  gnt, rvalid, rdata, busy
   );

   modport slave (
      input  req, wren, addr, wdata,
      output gnt, rvalid, rdata, busy
   );

endinterface

// File: rtl/s_mem_arbiter_fixed_prio_sel.sv
// fixed_prio_sel -- combinational fixed-priority selector.
//   vec    : request vector
//   onehot : lowest set bit of vec (zero when vec is zero)
//   idx    : encoded position of that bit (zero when vec is zero)
module fixed_prio_sel #(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] vec,
   output logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the lowest set index is the last to write.
   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter -- fixed-priority, non-preemptive arbiter for the single-port
// 256x8 S RAM shared by the RC4 init / KSA / PRGA engines.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : requester bus (s_mem_arbiter_if.slave)
//   mem_addr/mem_data/mem_wren : RAM address, write data, write enable
//   mem_q        : RAM read data, valid one clock after the address edge
// A requester that wins keeps the memory until it drops req; every cycle it
// holds both req and gnt is a memory access. Reads are tagged with the owner
// so the return lands on the right requester even after the grant is gone.
module s_mem_arbiter
   import rc4_pkg::*;
#(
   parameter int N_REQ = REQ_NUM,
   parameter int AW    = ARB_AW,
   parameter int DW    = ARB_DW
) (
   input  logic               clk,
   input  logic               reset_n,
   s_mem_arbiter_if.slave     bus,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_data,
   output logic               mem_wren,
   input  logic [DW-1:0]      mem_q
);

   localparam int IDX_W = idx_w(N_REQ);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             pend_q, pend_d;
   logic [IDX_W-1:0] tag_q, tag_d;

   logic [N_REQ-1:0] sel_onehot;
   logic [IDX_W-1:0] sel_idx;

   logic             own_ok;
   logic             own_req;
   logic             own_gnt;
   logic             own_wren;
   logic [N_REQ-1:0] own_onehot;
   logic [AW-1:0]    own_addr;
   logic [DW-1:0]    own_wdata;
   logic             access;

   fixed_prio_sel #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_sel (
      .vec    (bus.req),
      .onehot (sel_onehot),
      .idx    (sel_idx)
   );

   // Owner mux; own_ok stays low for an owner index beyond N_REQ-1.
   always_comb begin
      own_ok     = 1'b0;
      own_req    = 1'b0;
      own_gnt    = 1'b0;
      own_wren   = 1'b0;
      own_onehot = '0;
      own_addr   = '0;
      own_wdata  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_ok        = 1'b1;
            own_req       = bus.req[i];
            own_gnt       = gnt_q[i];
            own_wren      = bus.wren[i];
            own_onehot[i] = 1'b1;
            own_addr      = bus.addr[i*AW +: AW];
            own_wdata     = bus.wdata[i*DW +: DW];
         end
      end
   end

   // Next-state: default is "back to ARB, no grant", which also covers an
   // illegal state or a corrupted owner index.
   always_comb begin
      state_d = ST_ARB;
      owner_d = owner_q;
      gnt_d   = '0;
      case (state_q)
         ST_ARB: begin
            if (|bus.req) begin
               state_d = ST_OWN;
               owner_d = sel_idx;
               gnt_d   = sel_onehot;
            end
         end
         ST_OWN: begin
            if (!own_ok) begin
               owner_d = '0;
            end else if (own_req) begin
               state_d = ST_OWN;
               gnt_d   = own_onehot;
            end
         end
         default: owner_d = '0;
      endcase
   end

   assign access = (state_q == ST_OWN) && own_ok && own_req && own_gnt;

   always_comb begin
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
      pend_d   = 1'b0;
      tag_d    = tag_q;
      if (access) begin
         mem_addr = own_addr;
         mem_data = own_wdata;
         mem_wren = own_wren;
         pend_d   = !own_wren;
         tag_d    = owner_q;
      end
   end

   // Read return: one cycle after the read access, routed by the tag.
   always_comb begin
      bus.rvalid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pend_q && (tag_q == IDX_W'(i))) begin
            bus.rvalid[i] = 1'b1;
         end
      end
      bus.rdata = pend_q ? mem_q : '0;
   end

   assign bus.gnt  = gnt_q;
   assign bus.busy = (state_q == ST_OWN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ARB;
         owner_q <= '0;
         gnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         pend_q  <= pend_d;
      end
   end

   // Tag is only meaningful while pend_q is set, so it needs no reset.
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
   end

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter -- directed bench for s_mem_arbiter with a read-return
// scoreboard and a behavioural 256x8 synchronous RAM.
module tb_s_mem_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   s_mem_arbiter_if #(.N_REQ(3), .AW(8), .DW(8)) bus ();

   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_wren;
   logic [7:0] mem_q;
   logic [7:0] ram [256];

   s_mem_arbiter #(.N_REQ(3), .AW(8), .DW(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wren (mem_wren),
      .mem_q    (mem_q)
   );

   // RAM: write and registered read, read returns the pre-write contents.
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      mem_q <= ram[mem_addr];
   end

   typedef struct packed {
      logic [2:0] vld;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int total  = 0;
   int bad    = 0;
   int wr_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int i, input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
      bus.req[i]            = r;
      bus.wren[i]           = w;
      bus.addr[i*8 +: 8]    = a;
      bus.wdata[i*8 +: 8]   = d;
   endtask

   task automatic push(input int tag, input logic [7:0] d);
      exp_t e;
      e.vld  = 3'b001 << tag;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: counts write cycles and checks every read return.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_wren) wr_cnt++;
         if (bus.rvalid != 3'b000) begin
            if (sb.size() == 0) begin
               chk("rvalid_unexpected", {29'd0, bus.rvalid}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rvalid", {29'd0, bus.rvalid}, {29'd0, e.vld});
               chk("rdata", {24'd0, bus.rdata}, {24'd0, e.data});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req   = '0;
      bus.wren  = '0;
      bus.addr  = '0;
      bus.wdata = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", {29'd0, bus.gnt}, 32'd0);
      chk("rst_rvalid", {29'd0, bus.rvalid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_wren", {31'd0, mem_wren}, 32'd0);
      step();
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_gnt", {29'd0, bus.gnt}, 32'd0);
      step();

      // All three request at once: index 0 wins and initialises the RAM
      drive(0, 1'b1, 1'b1, 8'h00, 8'h00);
      drive(1, 1'b1, 1'b0, 8'h11, 8'h00);
      drive(2, 1'b1, 1'b0, 8'h22, 8'h00);
      @(negedge clk);
      chk("pregrant_gnt", {29'd0, bus.gnt}, 32'd0);
      chk("pregrant_wren", {31'd0, mem_wren}, 32'd0);
      chk("pregrant_addr", {24'd0, mem_addr}, 32'd0);
      step();
      for (int k = 0; k < 256; k++) begin
         drive(0, 1'b1, 1'b1, 8'(k), 8'(k));
         @(negedge clk);
         chk("init_gnt", {29'd0, bus.gnt}, 32'd1);
         chk("init_wren", {31'd0, mem_wren}, 32'd1);
         chk("init_addr", {24'd0, mem_addr}, 32'(k));
         chk("init_data", {24'd0, mem_data}, 32'(k));
         step();
      end
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(2, 1'b1, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("init_drop_wren", {31'd0, mem_wren}, 32'd0);
      chk("init_wr_cnt", 32'(wr_cnt), 32'd256);
      step();
      @(negedge clk);
      chk("bubble_gnt", {29'd0, bus.gnt}, 32'd0);
      chk("bubble_busy", {31'd0, bus.busy}, 32'd0);
      step();

      // Readback through requester 2
      for (int k = 0; k < 256; k++) begin
         drive(2, 1'b1, 1'b0, 8'(k), 8'h00);
         push(2, 8'(k));
         @(negedge clk);
         chk("rb_gnt", {29'd0, bus.gnt}, 32'd4);
         chk("rb_wren", {31'd0, mem_wren}, 32'd0);
         step();
      end
      drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("rb_tail_wren", {31'd0, mem_wren}, 32'd0);
      step();
      @(negedge clk);
      chk("rb_done_gnt", {29'd0, bus.gnt}, 32'd0);
      step();

      // Requester 1: single read of 0x10, then release
      drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
      step();
      push(1, 8'h10);
      @(negedge clk);
      chk("r1_gnt", {29'd0, bus.gnt}, 32'd2);
      chk("r1_addr", {24'd0, mem_addr}, 32'h10);
      step();
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("r1_drop_wren", {31'd0, mem_wren}, 32'd0);
      step();
      @(negedge clk);
      chk("r1_release_gnt", {29'd0, bus.gnt}, 32'd0);
      step();

      // Requester 2 owns; requester 0 cannot preempt
      drive(2, 1'b1, 1'b1, 8'h20, 8'h20);
      step();
      drive(0, 1'b1, 1'b1, 8'h30, 8'h30);
      @(negedge clk);
      chk("np_gnt0", {29'd0, bus.gnt}, 32'd4);
      chk("np_addr", {24'd0, mem_addr}, 32'h20);
      step();
      @(negedge clk);
      chk("np_gnt1", {29'd0, bus.gnt}, 32'd4);
      step();
      drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("np_noacc_addr", {24'd0, mem_addr}, 32'd0);
      chk("np_noacc_wren", {31'd0, mem_wren}, 32'd0);
      step();
      @(negedge clk);
      chk("np_bubble_gnt", {29'd0, bus.gnt}, 32'd0);
      step();
      @(negedge clk);
      chk("np_new_gnt", {29'd0, bus.gnt}, 32'd1);
      chk("np_new_addr", {24'd0, mem_addr}, 32'h30);
      chk("np_new_wren", {31'd0, mem_wren}, 32'd1);
      step();

      // Alternating write 0xAA / read at 0xFF by requester 0
      for (int r = 0; r < 4; r++) begin
         drive(0, 1'b1, 1'b1, 8'hFF, 8'hAA);
         @(negedge clk);
         chk("alt_wr_wren", {31'd0, mem_wren}, 32'd1);
         step();
         drive(0, 1'b1, 1'b0, 8'hFF, 8'h00);
         push(0, 8'hAA);
         @(negedge clk);
         chk("alt_rd_wren", {31'd0, mem_wren}, 32'd0);
         step();
      end
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      step();
      step();

      // Reset pulse while a read is pending
      drive(2, 1'b1, 1'b0, 8'h05, 8'h00);
      step();
      step();
      reset_n = 1'b0;
      drive(2, 1'b1, 1'b1, 8'h05, 8'h05);
      #1;
      chk("mrst_rvalid", {29'd0, bus.rvalid}, 32'd0);
      chk("mrst_gnt", {29'd0, bus.gnt}, 32'd0);
      chk("mrst_wren", {31'd0, mem_wren}, 32'd0);
      chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
      step();
      @(negedge clk);
      chk("mrst_hold_gnt", {29'd0, bus.gnt}, 32'd0);
      step();
      reset_n = 1'b1;
      @(negedge clk);
      chk("mrst_rel_gnt", {29'd0, bus.gnt}, 32'd0);
      step();
      @(negedge clk);
      chk("mrst_first_gnt", {29'd0, bus.gnt}, 32'd4);
      step();
      drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
      step();
      step();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
